// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
//   Shares the single-port grid RAM between the video renderer (read-only,
//   absolute priority), game logic (port A) and the line-clear engine
//   (port B). A and B are round-robin arbitrated in cycles without a video
//   request. The granted access is registered onto the RAM port one cycle
//   later. Read ownership travels alongside the RAM latency in a tag pipeline
//   and steers the returned data to the requester.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   vid_req/addr               renderer read strobe and address
//   vid_rdata/rvalid           renderer read return
//   a_* / b_*                  requester ports: req, we, addr, wdata in;
//                              gnt (combinational), rdata, rvalid out
//   mem_en/we/addr/wdata       RAM access, registered
//   mem_rdata                  RAM read data, MEM_LATENCY cycles after mem_en
//   starve[1:0]                sticky starvation flags, [0] = A, [1] = B
//
// Round-robin pointer
//   rr   | meaning
//   RR_A | A wins when A and B both request
//   RR_B | B wins when A and B both request
module grid_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        starve
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {TAG_NONE, TAG_V, TAG_A, TAG_B} tag_t;
  typedef enum logic {RR_A, RR_B} rr_t;

  rr_t               rr_q, rr_d;
  logic              issue, issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  tag_t              issue_tag;
  tag_t              tag_q [MEM_LATENCY+1];
  tag_t              ret_tag;
  logic [CNT_W-1:0]  wait_cnt [2];
  logic [1:0]        req_v, gnt_v;

  // Arbitration and next-access selection. Address/wdata default to the
  // current RAM port values so idle cycles hold them.
  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    rr_d        = rr_q;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_tag   = TAG_NONE;
    issue_addr  = mem_addr;
    issue_wdata = mem_wdata;
    if (!reset) begin
      if (vid_req) begin
        issue      = 1'b1;
        issue_tag  = TAG_V;
        issue_addr = vid_addr;
      end else if (a_req && (!b_req || rr_q == RR_A)) begin
        a_gnt       = 1'b1;
        rr_d        = RR_B;
        issue       = 1'b1;
        issue_we    = a_we;
        issue_addr  = a_addr;
        issue_wdata = a_wdata;
        issue_tag   = a_we ? TAG_NONE : TAG_A;
      end else if (b_req) begin
        b_gnt       = 1'b1;
        rr_d        = RR_A;
        issue       = 1'b1;
        issue_we    = b_we;
        issue_addr  = b_addr;
        issue_wdata = b_wdata;
        issue_tag   = b_we ? TAG_NONE : TAG_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= RR_A;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rr_q      <= rr_d;
      mem_en    <= issue;
      mem_we    <= issue_we;
      mem_addr  <= issue_addr;
      mem_wdata <= issue_wdata;
    end
  end

  // tag_q[0] lines up with mem_en; tag_q[MEM_LATENCY] with valid mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MEM_LATENCY; i++) tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i <= MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret_tag = tag_q[MEM_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_rvalid <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      vid_rdata  <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      vid_rvalid <= (ret_tag == TAG_V);
      a_rvalid   <= (ret_tag == TAG_A);
      b_rvalid   <= (ret_tag == TAG_B);
      if (ret_tag == TAG_V) vid_rdata <= mem_rdata;
      if (ret_tag == TAG_A) a_rdata   <= mem_rdata;
      if (ret_tag == TAG_B) b_rdata   <= mem_rdata;
    end
  end

  assign req_v = {b_req, a_req};
  assign gnt_v = {b_gnt, a_gnt};

  // Wait counters saturate at the limit; the flag sets on the same edge the
  // counter reaches it and then stays until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt[0] <= '0;
      wait_cnt[1] <= '0;
      starve      <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] || gnt_v[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != LIMIT_C) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
          if (wait_cnt[i] == LIMIT_M1) starve[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Testbench for grid_mem_arbiter: directed stimulus, a behavioural RAM, and a
// per-cycle compare against a transaction-level model of the arbiter.
module tb_grid_mem_arbiter;
  localparam int LAT   = 1;
  localparam int LIMIT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       vid_req, vid_rvalid;
  logic [7:0] vid_addr, vid_rdata;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [1:0] starve;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grid_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve(starve)
  );

  // Unwritten RAM locations hold a fixed pattern; 0x15 holds 0x37.
  function automatic logic [7:0] dflt(input logic [7:0] a);
    return (a == 8'h15) ? 8'h37 : (a ^ 8'hA5);
  endfunction

  // Grid RAM, one-cycle read latency.
  logic [7:0] ram_dat [256];
  bit         ram_wr  [256];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram_dat[mem_addr] <= mem_wdata;
      ram_wr[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= ram_wr[mem_addr] ? ram_dat[mem_addr] : dflt(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int         due;
    int         owner;   // 0 = video, 1 = A, 2 = B
    logic [7:0] data;
  } ret_t;

  int         cyc = 0;
  bit         known = 0;
  bit         pref_b = 0;
  int         wait_run [2];
  bit         starve_m [2];
  ret_t       rq [$];
  logic [7:0] sh_dat [256];
  bit         sh_wr  [256];
  bit         pend_v = 0, pend_we = 0;
  logic [7:0] pend_addr, pend_wdata, last_addr;
  logic [7:0] exp_rd [3];

  function automatic logic [7:0] model_read(input logic [7:0] a);
    return sh_wr[a] ? sh_dat[a] : dflt(a);
  endfunction

  always @(negedge clk) begin : compare
    bit         eg_a, eg_b;
    bit         ev [3];
    logic [7:0] ea;
    ret_t       r;
    eg_a = 1'b0;
    eg_b = 1'b0;
    if (!reset && !vid_req) begin
      if (a_req && (!b_req || !pref_b)) eg_a = 1'b1;
      else if (b_req)                   eg_b = 1'b1;
    end
    chk("a_gnt", a_gnt, eg_a);
    chk("b_gnt", b_gnt, eg_b);

    ev = '{0, 0, 0};
    if (rq.size() != 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      ev[r.owner]     = 1'b1;
      exp_rd[r.owner] = r.data;
    end
    if (known) begin
      ea = pend_v ? pend_addr : last_addr;
      chk("mem_en", mem_en, pend_v);
      chk("mem_we", mem_we, pend_v && pend_we);
      chk("mem_addr", mem_addr, ea);
      if (pend_v && pend_we) chk("mem_wdata", mem_wdata, pend_wdata);
      chk("vid_rvalid", vid_rvalid, ev[0]);
      chk("a_rvalid", a_rvalid, ev[1]);
      chk("b_rvalid", b_rvalid, ev[2]);
      chk("vid_rdata", vid_rdata, exp_rd[0]);
      chk("a_rdata", a_rdata, exp_rd[1]);
      chk("b_rdata", b_rdata, exp_rd[2]);
      chk("starve", starve, {starve_m[1], starve_m[0]});
      last_addr = ea;
    end

    if (reset) begin
      known     = 1'b1;
      pend_v    = 1'b0;
      pend_we   = 1'b0;
      last_addr = '0;
      pref_b    = 1'b0;
      rq.delete();
      for (int i = 0; i < 3; i++) exp_rd[i] = '0;
      for (int i = 0; i < 2; i++) begin
        wait_run[i] = 0;
        starve_m[i] = 1'b0;
      end
    end else begin
      pend_v  = 1'b0;
      pend_we = 1'b0;
      if (vid_req) begin
        pend_v    = 1'b1;
        pend_addr = vid_addr;
        r.due = cyc + 2 + LAT; r.owner = 0; r.data = model_read(vid_addr);
        rq.push_back(r);
      end else if (eg_a || eg_b) begin
        pend_v     = 1'b1;
        pend_we    = eg_a ? a_we    : b_we;
        pend_addr  = eg_a ? a_addr  : b_addr;
        pend_wdata = eg_a ? a_wdata : b_wdata;
        if (pend_we) begin
          sh_dat[pend_addr] = pend_wdata;
          sh_wr[pend_addr]  = 1'b1;
        end else begin
          r.due = cyc + 2 + LAT; r.owner = eg_a ? 1 : 2; r.data = model_read(pend_addr);
          rq.push_back(r);
        end
        pref_b = eg_a;
      end
      if (a_req && !eg_a) begin
        wait_run[0]++;
        if (wait_run[0] >= LIMIT) starve_m[0] = 1'b1;
      end else wait_run[0] = 0;
      if (b_req && !eg_b) begin
        wait_run[1]++;
        if (wait_run[1] >= LIMIT) starve_m[1] = 1'b1;
      end else wait_run[1] = 0;
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vid_req = 1'b0; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_rvalid"}, {vid_rvalid, a_rvalid, b_rvalid}, 0);
    chk({tag, "_starve"}, starve, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] pat_a, pat_b;
    pat_a = 8'b10100101;   // bit k: expected a_gnt in round-robin cycle k
    pat_b = 8'b01010010;   // bit k: expected b_gnt; cycle 3 is a video cycle

    reset = 1'b1; vid_req = 1'b1; a_req = 1'b1; b_req = 1'b1;
    a_we = 1'b0; b_we = 1'b0;
    vid_addr = 8'h00; a_addr = 8'h01; b_addr = 8'h02; a_wdata = '0; b_wdata = '0;

    // 1: reset with every request high, then one cycle after
    repeat (2) begin
      @(negedge clk); chk_quiet("t1_rst");
      step();
    end
    reset = 1'b0;
    @(negedge clk); chk_quiet("t1_after");
    step();
    idle();
    repeat (4) step();

    // 2: single video read, latency 3
    vid_req = 1'b1; vid_addr = 8'h15;
    step();
    vid_req = 1'b0;
    @(negedge clk);
    chk("t2_mem_en", mem_en, 1);
    chk("t2_mem_addr", mem_addr, 8'h15);
    chk("t2_rv_t1", vid_rvalid, 0);
    step(); @(negedge clk); chk("t2_rv_t2", vid_rvalid, 0);
    step(); @(negedge clk); chk("t2_rv_t3", vid_rvalid, 1); chk("t2_rdata", vid_rdata, 8'h37);
    step(); @(negedge clk); chk("t2_rv_t4", vid_rvalid, 0);
    step();

    // 3: A and B both reading, one video cycle mixed in
    a_req = 1'b1; b_req = 1'b1; a_addr = 8'h30; b_addr = 8'h40; vid_addr = 8'h60;
    for (int k = 0; k < 8; k++) begin
      vid_req = (k == 3);
      @(negedge clk);
      chk($sformatf("t3_a_gnt%0d", k), a_gnt, pat_a[k]);
      chk($sformatf("t3_b_gnt%0d", k), b_gnt, pat_b[k]);
      if (k > 0) chk($sformatf("t3_mem_en%0d", k), mem_en, 1);
      step();
      if (pat_a[k]) a_addr = a_addr + 8'd1;
      if (pat_b[k]) b_addr = b_addr + 8'd1;
    end
    idle();
    repeat (5) step();

    // 4: video hogs the RAM for 70 cycles while A waits
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h50; vid_req = 1'b1;
    for (int k = 0; k < 70; k++) begin
      vid_addr = 8'(k);
      @(negedge clk);
      chk($sformatf("t4_a_gnt%0d", k), a_gnt, 0);
      chk($sformatf("t4_starve%0d", k), starve[0], (k >= LIMIT));
      step();
    end
    vid_req = 1'b0;
    @(negedge clk); chk("t4_release_gnt", a_gnt, 1);
    step();
    idle();
    repeat (4) step();

    // 5: A write; no read return
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'h05;
    @(negedge clk); chk("t5_gnt", a_gnt, 1);
    step();
    idle();
    @(negedge clk);
    chk("t5_mem_en", mem_en, 1); chk("t5_mem_we", mem_we, 1);
    chk("t5_mem_addr", mem_addr, 8'h20); chk("t5_mem_wdata", mem_wdata, 8'h05);
    for (int k = 0; k < 4; k++) begin
      step(); @(negedge clk); chk($sformatf("t5_no_rv%0d", k), a_rvalid, 0);
    end
    step();

    // B writes top address, A reads it the very next cycle
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 8'h9C;
    @(negedge clk); chk("wr_rd_b_gnt", b_gnt, 1);
    step();
    b_req = 1'b0; b_we = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 8'hFF;
    @(negedge clk); chk("wr_rd_a_gnt", a_gnt, 1);
    step();
    a_req = 1'b0;
    step(); step();
    @(negedge clk); chk("wr_rd_rvalid", a_rvalid, 1); chk("wr_rd_rdata", a_rdata, 8'h9C);
    step();
    repeat (3) step();

    // 6: B read killed by reset
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h33;
    @(negedge clk); chk("t6_b_gnt", b_gnt, 1);
    step();
    b_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("t6_no_b_rv%0d", k), b_rvalid, 0);
      step();
    end

    // pointer returns to A after reset even though A was served last
    a_req = 1'b1; a_addr = 8'h44;
    @(negedge clk); chk("t6_a_only_gnt", a_gnt, 1);
    step();
    a_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; a_req = 1'b1; b_req = 1'b1; a_addr = 8'h45; b_addr = 8'h46;
    @(negedge clk);
    chk("t6_rr_a_gnt", a_gnt, 1); chk("t6_rr_b_gnt", b_gnt, 0);
    chk("t6_starve_clr", starve, 0);
    step();
    idle();
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
